alu_seq: RTL
============

# alu_seq

Sequential, parametrised successor to the combinational accumulator ALU. It sits between the accumulator/register file and the control unit. It accepts an operation with a start pulse and returns a registered result plus registered flags with a one-cycle `done` pulse. It adds carry/borrow and sign flags, true rotates, multi-bit shifts and an iterative multiply that runs over several cycles with a `busy` handshake.

## Interface
- `DATA_WIDTH`, 8: operand/result width; ≥ 4.
- `OP_WIDTH`, 4: opcode width; only the low 4 bits are decoded.
- `SH_WIDTH`, `$clog2(DATA_WIDTH)`: width of the shift-amount field taken from `in2_reg`.

Ports:
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: request; sampled only while `busy`=0.
- `operation` input OP_WIDTH: opcode, sampled with `start`.
- `in1_acc` input DATA_WIDTH: accumulator operand, sampled with `start`.
- `in2_reg` input DATA_WIDTH: register/immediate operand, sampled with `start`.
- `busy` output 1: a multi-cycle operation is in progress.
- `done` output 1: one-cycle pulse; result and flags are valid and updated.
- `data_out` output DATA_WIDTH: registered result, held until the next `done`.
- `zero_f` output 1: `data_out`==0.
- `carry_f` output 1: carry/borrow/shift-out (see Operation).
- `neg_f` output 1: `data_out[DATA_WIDTH-1]`.
- `gr_z_f` output 1: `data_out` is nonzero and its MSB is 0.

## Operation
- States: IDLE, SHIFT, MUL. All outputs are registered; the flags are computed from the next result and loaded on the same edge as `data_out`.
- Opcodes:
  - 0 NOP (returns `in1_acc`)
  - 1 XOR
  - 2 OR
  - 3 AND
  - 4 SUB (`in1_acc`-`in2_reg`)
  - 5 ADD
  - 6 ROR by 1 (LSB wraps to MSB)
  - 7 ROL by 1
  - 8 DEC
  - 9 INC
  - A NOT
  - B LD (returns `in2_reg`)
  - C SHR by N
  - D SHL by N
  - E MUL
  - F NOP
- N = `in2_reg[SH_WIDTH-1:0]`.
- `carry_f` by opcode:
  - ADD/INC: carry-out of the DATA_WIDTH+1-bit sum.
  - SUB/DEC: borrow.
  - ROR/ROL: the bit that wrapped.
  - SHR/SHL: the last bit shifted out; 0 if N=0.
  - MUL: 1 if the upper half of the 2×DATA_WIDTH product is nonzero.
  - All other opcodes: 0.
- Overflow: results truncate to DATA_WIDTH (wrap-around), e.g. FF+01 → 00.
- Single-cycle opcodes (0–B, F, and C/D with N=0): IDLE→IDLE.
- SHIFT: latch the operand and N, then shift one bit per cycle, decrementing the counter. At count 0, load the result and return to IDLE.
- MUL: radix-2 shift-add over DATA_WIDTH iterations using a 2×DATA_WIDTH accumulator. `data_out` receives the low half. Return to IDLE.
- `start` while `busy`=1 is ignored; operands and opcode are not re-sampled.
- Reset (any state, including mid-SHIFT or mid-MUL): abort immediately. State goes to IDLE and the counters clear.
- Reset values: `data_out`=0, `busy`=0, `done`=0, and all flags 0. `zero_f` is 0 at reset because it is registered.

## Timing
- `start` is sampled at edge t0.
- Single-cycle op: `data_out`, flags and `done`=1 update at t0. Latency is 1 cycle. `busy` stays 0.
- SHIFT with N>0: `busy`=1 from t0. Result, flags and `done` arrive at edge t0+N, where `busy` falls.
- MUL: `busy`=1 from t0. Result and `done` arrive at t0+DATA_WIDTH, where `busy` falls.
- `done` is high for exactly one cycle. A new `start` is accepted on the edge where `busy` falls, so back-to-back single-cycle ops give one result per cycle.
- `data_out` and the flags do not change between `done` pulses.

## Configuration
- `ALU_MUL_EN` defined: opcode E is the iterative multiplier described above, including the MUL state.
- Not defined: the MUL state and product register are not built. Opcode E behaves as a single-cycle NOP (`data_out`=`in1_acc`, `carry_f`=0).

## Test plan
- ADD, `in1_acc`=8'hFF, `in2_reg`=8'h01, single `start` → one cycle later: `data_out`=00, `zero_f`=1, `carry_f`=1, `done`=1 for one cycle, `busy` never high.
- SUB 8'h03−8'h05 → `data_out`=FE, `carry_f`=1, `neg_f`=1, `gr_z_f`=0. ROR 8'h01 → 80, `carry_f`=1.
- SHL by N=3 of 8'h81 → `busy` high 3 cycles, then `data_out`=08, `carry_f`=0, `done` at t0+3. SHR N=0 of 8'h81 → single-cycle, `data_out`=81.
- MUL 13×11 (`ALU_MUL_EN` on) → `done` at t0+8, `data_out`=8F, `carry_f`=0. MUL 8'h20×8'h10 → 00, `zero_f`=1, `carry_f`=1. With the macro off, MUL 13×11 → 0D after 1 cycle.
- Pulse `start` with XOR mid-MUL → ignored; the MUL result is unchanged and `done` fires exactly once.
- Assert `rst_n`=0 at t0+4 of a MUL → all outputs 0 immediately. After release, ADD 2+3 → 05 in one cycle.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU with registered result/flags, multi-bit shifts and an optional
// iterative radix-2 multiplier (enabled by defining ALU_MUL_EN).
module alu_seq #(
    parameter int DATA_WIDTH = 8,
    parameter int OP_WIDTH   = 4,
    parameter int SH_WIDTH   = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [OP_WIDTH-1:0]   operation,
    input  logic [DATA_WIDTH-1:0] in1_acc,
    input  logic [DATA_WIDTH-1:0] in2_reg,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  zero_f,
    output logic                  carry_f,
    output logic                  neg_f,
    output logic                  gr_z_f
);
    localparam int CNT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [3:0] {
        OP_NOP = 4'h0, OP_XOR = 4'h1, OP_OR  = 4'h2, OP_AND = 4'h3,
        OP_SUB = 4'h4, OP_ADD = 4'h5, OP_ROR = 4'h6, OP_ROL = 4'h7,
        OP_DEC = 4'h8, OP_INC = 4'h9, OP_NOT = 4'hA, OP_LD  = 4'hB,
        OP_SHR = 4'hC, OP_SHL = 4'hD, OP_MUL = 4'hE, OP_NP2 = 4'hF
    } op_e;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL} state_e;
`else
    typedef enum logic [1:0] {S_IDLE, S_SHIFT} state_e;
`endif

    state_e                r_state;
    logic [CNT_W-1:0]      r_cnt;
    logic [DATA_WIDTH-1:0] r_sh_val;
    logic                  r_sh_left;

    op_e                   w_op;
    logic [SH_WIDTH-1:0]   w_n;
    logic [DATA_WIDTH-1:0] w_res;
    logic                  w_carry;
    logic [DATA_WIDTH:0]   w_wide;
    logic                  w_multi;
    logic [DATA_WIDTH-1:0] w_sh_next;
    logic                  w_sh_out;
    logic                  w_fin;
    logic [DATA_WIDTH-1:0] w_fin_val;
    logic                  w_fin_c;

`ifdef ALU_MUL_EN
    logic [2*DATA_WIDTH-1:0] r_prod;
    logic [DATA_WIDTH-1:0]   r_mcand;
    logic [DATA_WIDTH:0]     w_psum;
    logic [2*DATA_WIDTH-1:0] w_prod_next;

    // Multiplier sits in the low half and is consumed LSB-first as the pair shifts right.
    always_comb begin
        w_psum      = {1'b0, r_prod[2*DATA_WIDTH-1:DATA_WIDTH]} +
                      (r_prod[0] ? {1'b0, r_mcand} : '0);
        w_prod_next = {w_psum, r_prod[DATA_WIDTH-1:1]};
    end
`endif

    assign w_op = op_e'(operation[3:0]);
    assign w_n  = in2_reg[SH_WIDTH-1:0];

    always_comb begin
        w_res   = in1_acc;
        w_carry = 1'b0;
        w_wide  = '0;
        case (w_op)
            OP_XOR: w_res = in1_acc ^ in2_reg;
            OP_OR:  w_res = in1_acc | in2_reg;
            OP_AND: w_res = in1_acc & in2_reg;
            OP_SUB: begin
                w_wide  = {1'b0, in1_acc} - {1'b0, in2_reg};
                w_res   = w_wide[DATA_WIDTH-1:0];
                w_carry = w_wide[DATA_WIDTH];
            end
            OP_ADD: begin
                w_wide  = {1'b0, in1_acc} + {1'b0, in2_reg};
                w_res   = w_wide[DATA_WIDTH-1:0];
                w_carry = w_wide[DATA_WIDTH];
            end
            OP_ROR: begin
                w_res   = {in1_acc[0], in1_acc[DATA_WIDTH-1:1]};
                w_carry = in1_acc[0];
            end
            OP_ROL: begin
                w_res   = {in1_acc[DATA_WIDTH-2:0], in1_acc[DATA_WIDTH-1]};
                w_carry = in1_acc[DATA_WIDTH-1];
            end
            OP_DEC: begin
                w_res   = in1_acc - 1'b1;
                w_carry = (in1_acc == '0);
            end
            OP_INC: begin
                w_res   = in1_acc + 1'b1;
                w_carry = (in1_acc == '1);
            end
            OP_NOT: w_res = ~in1_acc;
            OP_LD:  w_res = in2_reg;
            default: ;
        endcase
    end

    always_comb begin
        w_multi = ((w_op == OP_SHR) || (w_op == OP_SHL)) && (w_n != '0);
`ifdef ALU_MUL_EN
        if (w_op == OP_MUL) w_multi = 1'b1;
`endif
    end

    assign w_sh_next = r_sh_left ? {r_sh_val[DATA_WIDTH-2:0], 1'b0}
                                 : {1'b0, r_sh_val[DATA_WIDTH-1:1]};
    assign w_sh_out  = r_sh_left ? r_sh_val[DATA_WIDTH-1] : r_sh_val[0];

    // Single point that decides when and what gets loaded into the result/flag registers.
    always_comb begin
        w_fin     = 1'b0;
        w_fin_val = w_res;
        w_fin_c   = w_carry;
        case (r_state)
            S_IDLE:  w_fin = start && !w_multi;
            S_SHIFT: begin
                w_fin     = (r_cnt == CNT_W'(1));
                w_fin_val = w_sh_next;
                w_fin_c   = w_sh_out;
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
                w_fin     = (r_cnt == CNT_W'(1));
                w_fin_val = w_prod_next[DATA_WIDTH-1:0];
                w_fin_c   = |w_prod_next[2*DATA_WIDTH-1:DATA_WIDTH];
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_sh_val  <= '0;
            r_sh_left <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            data_out  <= '0;
            zero_f    <= 1'b0;
            carry_f   <= 1'b0;
            neg_f     <= 1'b0;
            gr_z_f    <= 1'b0;
`ifdef ALU_MUL_EN
            r_prod    <= '0;
            r_mcand   <= '0;
`endif
        end else begin
            done <= w_fin;
            if (w_fin) begin
                data_out <= w_fin_val;
                zero_f   <= (w_fin_val == '0);
                carry_f  <= w_fin_c;
                neg_f    <= w_fin_val[DATA_WIDTH-1];
                gr_z_f   <= (w_fin_val != '0) && !w_fin_val[DATA_WIDTH-1];
            end
            case (r_state)
                S_IDLE: begin
                    if (start && w_multi) begin
                        busy <= 1'b1;
`ifdef ALU_MUL_EN
                        if (w_op == OP_MUL) begin
                            r_prod  <= {{DATA_WIDTH{1'b0}}, in1_acc};
                            r_mcand <= in2_reg;
                            r_cnt   <= CNT_W'(DATA_WIDTH);
                            r_state <= S_MUL;
                        end else
`endif
                        begin
                            r_sh_val  <= in1_acc;
                            r_sh_left <= (w_op == OP_SHL);
                            r_cnt     <= CNT_W'(w_n);
                            r_state   <= S_SHIFT;
                        end
                    end
                end
                S_SHIFT: begin
                    r_sh_val <= w_sh_next;
                    r_cnt    <= r_cnt - CNT_W'(1);
                    if (w_fin) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
`ifdef ALU_MUL_EN
                S_MUL: begin
                    r_prod <= w_prod_next;
                    r_cnt  <= r_cnt - CNT_W'(1);
                    if (w_fin) begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
